// File: rtl/noc_arb_pkg.sv
// -----------------------------------------------------------------------------
// noc_arb_pkg
// Shared types and helpers for the NoC output-port packet arbiter.
//   arb_state_t : arbiter FSM states (IDLE, LOCKED)
//   rr_next()   : round-robin pick, first set request above ptr with wrap
// -----------------------------------------------------------------------------
package noc_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // rr_next works on a fixed-width request vector so one function serves
    // every INPUTS value up to MAX_INPUTS.
    localparam int unsigned MAX_INPUTS = 32;
    localparam int unsigned MAX_IDX_W  = 5;
    localparam int unsigned IDX_EXT_W  = MAX_IDX_W + 1;

    // Returns the first set bit of req searching ptr+1, ptr+2, ... modulo n.
    // With no request set it returns ptr (caller qualifies with |req).
    function automatic logic [MAX_IDX_W-1:0] rr_next(
        input logic [MAX_INPUTS-1:0] req,
        input logic [MAX_IDX_W-1:0]  ptr,
        input logic [IDX_EXT_W-1:0]  n
    );
        logic [IDX_EXT_W-1:0] idx;
        logic                 found;
        rr_next = ptr;
        found   = 1'b0;
        for (int k = 1; k <= MAX_INPUTS; k++) begin
            // ptr < n and k <= n, so one conditional subtract is a full modulo.
            idx = {1'b0, ptr} + IDX_EXT_W'(k);
            if (idx >= n) idx = idx - n;
            if ((IDX_EXT_W'(k) <= n) && !found && req[idx[MAX_IDX_W-1:0]]) begin
                rr_next = idx[MAX_IDX_W-1:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/noc_out_port_arb_if.sv
// -----------------------------------------------------------------------------
// noc_out_port_arb_if
// Requester-side and link-side signals of one arbitrated NoC output port.
//   in_flit/in_last/in_valid/in_ready : INPUTS requester channels
//   out_flit/out_last/out_valid/out_ready : shared output link
//   grant_idx/busy : arbitration status
// Modports: slave = the arbiter, master = requesters + downstream link.
// -----------------------------------------------------------------------------
interface noc_out_port_arb_if #(
    parameter int INPUTS     = 5,
    parameter int FLIT_WIDTH = 32
);
    localparam int IDX_W = $clog2(INPUTS);

    logic [INPUTS*FLIT_WIDTH-1:0] in_flit;
    logic [INPUTS-1:0]            in_last;
    logic [INPUTS-1:0]            in_valid;
    logic [INPUTS-1:0]            in_ready;
    logic [FLIT_WIDTH-1:0]        out_flit;
    logic                         out_last;
    logic                         out_valid;
    logic                         out_ready;
    logic [IDX_W-1:0]             grant_idx;
    logic                         busy;

    modport slave (
        input  in_flit, in_last, in_valid, out_ready,
        output in_ready, out_flit, out_last, out_valid, grant_idx, busy
    );

    modport master (
        output in_flit, in_last, in_valid, out_ready,
        input  in_ready, out_flit, out_last, out_valid, grant_idx, busy
    );
endinterface

// File: rtl/noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter
// Purely combinational round-robin picker.
//   req     : per-requester request bits
//   ptr     : last granted requester (search starts at ptr+1)
//   gnt_idx : selected requester
//   gnt_any : at least one request present
// -----------------------------------------------------------------------------
module noc_rr_arbiter
    import noc_arb_pkg::*;
#(
    parameter int INPUTS = 5,
    parameter int IDX_W  = $clog2(INPUTS)
) (
    input  logic [INPUTS-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    assign gnt_idx = IDX_W'(rr_next(MAX_INPUTS'(req), MAX_IDX_W'(ptr), IDX_EXT_W'(INPUTS)));
    assign gnt_any = |req;

endmodule

// File: rtl/noc_out_port_arb.sv
// -----------------------------------------------------------------------------
// noc_out_port_arb
// Shares one NoC output link among INPUTS requesters. A requester is picked
// round-robin in IDLE and keeps the link for its whole wormhole packet, until
// its last flit is accepted. Flits pass through a one-entry output register.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : noc_out_port_arb_if.slave (requester channels, output link, status)
// -----------------------------------------------------------------------------
module noc_out_port_arb
    import noc_arb_pkg::*;
#(
    parameter int INPUTS     = 5,
    parameter int FLIT_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    noc_out_port_arb_if.slave   bus
);

    localparam int IDX_W = $clog2(INPUTS);

    arb_state_t            r_state;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_grant_idx;
    logic [FLIT_WIDTH-1:0] r_out_flit;
    logic                  r_out_last;
    logic                  r_out_valid;

    logic [IDX_W-1:0]      w_gnt_idx;
    logic                  w_gnt_any;
    logic                  w_can_load;
    logic                  w_accept;
    logic                  w_sel_last;
    logic [FLIT_WIDTH-1:0] w_sel_flit;
    logic [INPUTS-1:0]     w_in_ready;

    noc_rr_arbiter #(
        .INPUTS (INPUTS),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req     (bus.in_valid),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    // The output register can take a flit when empty or draining this cycle.
    assign w_can_load = ~r_out_valid | bus.out_ready;

    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_in_ready = '0;
        if (r_state == LOCKED) w_in_ready[r_grant_idx] = w_can_load;
    end

    assign w_sel_flit = bus.in_flit[r_grant_idx*FLIT_WIDTH +: FLIT_WIDTH];
    assign w_sel_last = bus.in_last[r_grant_idx];
    assign w_accept   = |(bus.in_valid & w_in_ready);

    // Grant FSM. Only the IDLE state consults the round-robin picker, so a
    // stalled packet keeps the lock no matter who else is requesting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ptr       <= IDX_W'(INPUTS - 1);
            r_grant_idx <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        r_grant_idx <= w_gnt_idx;
                        r_state     <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_accept && w_sel_last) begin
                        r_ptr   <= r_grant_idx;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // One-entry output stage: load wins over drain in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_flit  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_sel_last;
            r_out_flit  <= w_sel_flit;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_flit  = r_out_flit;
    assign bus.out_last  = r_out_last;
    assign bus.out_valid = r_out_valid;
    assign bus.grant_idx = r_grant_idx;
    assign bus.busy      = (r_state == LOCKED);

endmodule

// File: tb/tb_noc_out_port_arb.sv
// -----------------------------------------------------------------------------
// tb_noc_out_port_arb
// Self-checking bench for noc_out_port_arb. Requesters are packet queues; the
// reference model tracks which requester owns the link, the round-robin
// pointer and the queue of flits accepted but not yet delivered downstream.
// -----------------------------------------------------------------------------
module tb_noc_out_port_arb;

    localparam int INPUTS = 5;
    localparam int FW     = 32;

    typedef struct {
        logic [FW-1:0] flit;
        logic          last;
    } flit_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    noc_out_port_arb_if #(.INPUTS(INPUTS), .FLIT_WIDTH(FW)) bus();

    noc_out_port_arb #(.INPUTS(INPUTS), .FLIT_WIDTH(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    flit_t             src_q[INPUTS][$];
    flit_t             exp_q[$];
    flit_t             log_q[$];
    logic [INPUTS-1:0] en;
    logic              oready;
    bit                m_busy;
    int                m_owner;
    int                m_ptr;
    int                n_checks = 0;
    int                n_fail   = 0;
    int                n_pushed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Round-robin: walk the priority order ptr+1, ptr+2, ... (mod INPUTS).
    function automatic int rr_model(input logic [INPUTS-1:0] v, input int p);
        for (int k = 1; k <= INPUTS; k++)
            if (v[(p + k) % INPUTS]) return (p + k) % INPUTS;
        return p;
    endfunction

    task automatic push_pkt(input int i, input int len, input logic [FW-1:0] base);
        for (int k = 0; k < len; k++) begin
            src_q[i].push_back('{flit: base + FW'(k), last: (k == len - 1)});
            n_pushed++;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < INPUTS; i++) begin
            if (en[i] && src_q[i].size() != 0) begin
                bus.in_valid[i]          = 1'b1;
                bus.in_flit[i*FW +: FW]  = src_q[i][0].flit;
                bus.in_last[i]           = src_q[i][0].last;
            end else begin
                bus.in_valid[i]          = 1'b0;
                bus.in_flit[i*FW +: FW]  = FW'($urandom);
                bus.in_last[i]           = 1'($urandom_range(0, 1));
            end
        end
        bus.out_ready = oready;
    endtask

    // One clock cycle: drive, compare against the model, clock, advance model.
    task automatic cycle();
        logic [INPUTS-1:0] exp_rdy;
        logic [INPUTS-1:0] acc;
        bit                can;
        flit_t             e;
        drive_inputs();
        #1;
        can     = (exp_q.size() == 0) || oready;
        exp_rdy = '0;
        if (m_busy && can) exp_rdy[m_owner] = 1'b1;
        check("busy", 64'(bus.busy), 64'(m_busy));
        if (m_busy) check("grant_idx", 64'(bus.grant_idx), 64'(m_owner));
        check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            check("out_data", 64'({bus.out_last, bus.out_flit}), 64'({exp_q[0].last, exp_q[0].flit}));
        acc = bus.in_valid & exp_rdy;
        @(posedge clk);
        if (exp_q.size() != 0 && oready) log_q.push_back(exp_q.pop_front());
        if (acc != '0) begin
            for (int i = 0; i < INPUTS; i++) begin
                if (acc[i]) begin
                    e = src_q[i].pop_front();
                    exp_q.push_back(e);
                    if (e.last) begin
                        m_busy = 1'b0;
                        m_ptr  = m_owner;
                    end
                end
            end
        end else if (!m_busy && bus.in_valid != '0) begin
            m_owner = rr_model(bus.in_valid, m_ptr);
            m_busy  = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = INPUTS - 1;
        exp_q.delete();
        for (int i = 0; i < INPUTS; i++) src_q[i].delete();
        en     = '0;
        oready = 1'b1;
        drive_inputs();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        bit done;
        en     = '1;
        oready = 1'b1;
        done   = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            cycle();
            done = !m_busy && exp_q.size() == 0;
            for (int i = 0; i < INPUTS; i++) if (src_q[i].size() != 0) done = 1'b0;
        end
        check("drain_done", 64'(done), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] held;
        bit            bseq[6];
        int            seq;

        // ---------------- reset state ----------------
        do_reset();
        rst = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_last", 64'(bus.out_last), 64'(0));
        check("rst_out_flit", 64'(bus.out_flit), 64'(0));
        check("rst_grant_idx", 64'(bus.grant_idx), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        do_reset();

        // ---------------- single requester, 3-flit packet ----------------
        src_q[2].push_back('{flit: 32'hA, last: 1'b0});
        src_q[2].push_back('{flit: 32'hB, last: 1'b0});
        src_q[2].push_back('{flit: 32'hC, last: 1'b1});
        en = 5'b00100;
        cycle();
        check("t1_c1_busy", 64'(bus.busy), 64'(1));
        check("t1_c1_grant", 64'(bus.grant_idx), 64'(2));
        cycle();
        check("t1_c2_out", 64'({bus.out_valid, bus.out_flit}), 64'({1'b1, 32'hA}));
        cycle();
        check("t1_c3_out", 64'({bus.out_valid, bus.out_flit}), 64'({1'b1, 32'hB}));
        cycle();
        check("t1_c4_out", 64'({bus.out_valid, bus.out_last, bus.out_flit}), 64'({2'b11, 32'hC}));
        check("t1_c4_busy", 64'(bus.busy), 64'(0));
        drain();

        // ---------------- round-robin fairness ----------------
        do_reset();
        log_q.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < INPUTS; i++) push_pkt(i, 1, FW'(i));
        en = '1;
        for (int c = 0; c < 40 && log_q.size() < 6; c++) cycle();
        check("rr_count", 64'(log_q.size() >= 6), 64'(1));
        for (int k = 0; k < 6 && k < log_q.size(); k++)
            check($sformatf("rr_order%0d", k), 64'(log_q[k].flit), 64'(k % INPUTS));
        drain();

        // ---------------- packet lock with mid-packet gap ----------------
        log_q.delete();
        push_pkt(1, 4, 32'h100);
        en = 5'b00010;
        cycle();
        cycle();
        cycle();
        en[1] = 1'b0;
        push_pkt(3, 2, 32'h300);
        en[3] = 1'b1;
        cycle();
        check("lock_gap_grant", 64'(bus.grant_idx), 64'(1));
        cycle();
        check("lock_gap_busy", 64'(bus.busy), 64'(1));
        en[1] = 1'b1;
        drain();
        check("lock_count", 64'(log_q.size()), 64'(6));
        for (int k = 0; k < 4 && k < log_q.size(); k++)
            check($sformatf("lock_r1_%0d", k), 64'(log_q[k].flit), 64'(32'h100 + k));
        if (log_q.size() >= 6)
            check("lock_r3_first", 64'(log_q[4].flit), 64'(32'h300));

        // ---------------- backpressure ----------------
        log_q.delete();
        push_pkt(2, 6, 32'h200);
        en = 5'b00100;
        for (int c = 0; c < 4; c++) cycle();
        held   = bus.out_flit;
        oready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
            check("bp_hold", 64'({bus.out_valid, bus.out_flit}), 64'({1'b1, held}));
        end
        drain();
        check("bp_count", 64'(log_q.size()), 64'(6));
        for (int k = 0; k < 6 && k < log_q.size(); k++)
            check($sformatf("bp_seq%0d", k), 64'(log_q[k].flit), 64'(32'h200 + k));

        // ---------------- single-flit back-to-back ----------------
        log_q.delete();
        for (int k = 0; k < 3; k++) push_pkt(0, 1, FW'(32'h50 + k));
        en = 5'b00001;
        for (int c = 0; c < 6; c++) begin
            cycle();
            bseq[c] = bus.busy;
        end
        for (int c = 0; c < 6; c++)
            check($sformatf("b2b_busy%0d", c), 64'(bseq[c]), 64'((c % 2) == 0));
        drain();
        check("b2b_count", 64'(log_q.size()), 64'(3));

        // ---------------- reset mid-packet ----------------
        push_pkt(4, 4, 32'h400);
        en = 5'b10000;
        for (int c = 0; c < 3; c++) cycle();
        rst = 1'b0;
        #1;
        check("rmid_out_valid", 64'(bus.out_valid), 64'(0));
        check("rmid_busy", 64'(bus.busy), 64'(0));
        do_reset();
        push_pkt(4, 1, 32'h4AA);
        push_pkt(0, 1, 32'h0AA);
        en = '1;
        cycle();
        check("rmid_grant0", 64'({bus.busy, bus.grant_idx}), 64'({1'b1, 3'd0}));
        drain();

        // ---------------- randomized traffic ----------------
        log_q.delete();
        n_pushed = 0;
        seq      = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < INPUTS; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    push_pkt(i, int'($urandom_range(1, 4)), {4'(i), 28'(seq)});
                    seq += 8;
                end
                en[i] = ($urandom_range(0, 3) != 0);
            end
            oready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();
        check("rand_count", 64'(log_q.size()), 64'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_out_port_arb.md
# noc_out_port_arb

Per-output-port packet arbiter for the system NoC routers. It shares one router output link among `INPUTS` requesting input ports using round-robin arbitration. It holds each grant for a whole wormhole packet, until the flit with `last=1` is accepted. It drives the link through a one-entry registered output stage. One instance sits in front of every `noc_router` output (endpoint or router-to-router link) for one virtual channel.

## Interface
Parameters:
- `INPUTS`, 5: number of requesting input ports (≥2)
- `FLIT_WIDTH`, 32: flit width in bits; equals `CONFIG.NOC_FLIT_WIDTH`

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `in_flit`  in  INPUTS*FLIT_WIDTH  requester flits, requester i at bits [i*FLIT_WIDTH +: FLIT_WIDTH]
- `in_last`  in  INPUTS  last-flit-of-packet marker per requester
- `in_valid`  in  INPUTS  flit valid per requester
- `in_ready`  out  INPUTS  flit accepted from requester i when `in_valid[i] & in_ready[i]`
- `out_flit`  out  FLIT_WIDTH  registered output flit
- `out_last`  out  1  registered last marker
- `out_valid`  out  1  output flit valid
- `out_ready`  in  1  downstream accepts when `out_valid & out_ready`
- `grant_idx`  out  $clog2(INPUTS)  currently locked requester; meaningful only when `busy=1`
- `busy`  out  1  arbiter is in LOCKED

## Operation
- The state machine has two states: IDLE and LOCKED. A round-robin pointer `ptr` holds the last requester that was granted.
- In IDLE with any `in_valid` set, the arbiter picks the first set bit searching from `ptr+1` upward with wrap-around modulo INPUTS. It registers that index into `grant_idx` and moves to LOCKED. With no `in_valid` set it stays in IDLE.
- In LOCKED, `in_ready[grant_idx] = ~out_valid | out_ready`. All other `in_ready` bits are 0.
- An accepted flit loads `out_flit`/`out_last` and sets `out_valid=1`.
- When an accepted flit has `in_last=1`:
  - `ptr <= grant_idx`
  - the state moves to IDLE on the next cycle.
- `out_valid` clears when the downstream accepts and no new flit is loaded in the same cycle.
- If the granted requester drops `in_valid` mid-packet, the lock is held indefinitely. Other requesters are never granted until `last` is accepted.
- A single-flit packet (`in_last=1` on the first flit) takes one LOCKED cycle.
- Requests from non-granted inputs in IDLE never cause any acceptance in that same cycle.
- `in_valid` is not required to stay stable before grant, and `in_flit` is sampled only on acceptance.

## Timing
- Reset values (asynchronous on `rst=0`):
  - state IDLE
  - `ptr = INPUTS-1`, so requester 0 has first priority
  - `grant_idx = 0`
  - `busy = 0`, `out_valid = 0`, `out_last = 0`, `out_flit = 0`
  - `in_ready = 0` (combinational from the reset state)
- Latency: `in_valid` rises at cycle 0 (IDLE) → `busy=1` and `in_ready` at cycle 1 → flit accepted at cycle 1 → `out_valid` at cycle 2.
- Throughput is 1 flit/cycle within a packet while `out_ready=1`. There is exactly one IDLE bubble cycle between consecutive packets.
- Backpressure: with `out_valid=1` and `out_ready=0`, `in_ready` is 0 and the output register holds its value.
- Simultaneous drain and load (`out_valid & out_ready` plus an accepted flit) replaces the register contents and `out_valid` stays 1.
- Reset asserted mid-packet:
  - the output flit in flight is discarded (`out_valid` → 0 immediately)
  - the lock is released and `ptr` returns to INPUTS-1
- Cross-cycle behaviour of `busy`: it drops in the cycle after `last` is accepted, even if `out_valid` is still 1.

## Structure
- Package `noc_arb_pkg` holds:
  - `arb_state_t` (enum IDLE, LOCKED)
  - the function `rr_next(req, ptr)` that returns the granted index
- Sub-module `noc_rr_arbiter` is purely combinational. Its inputs are `req` [INPUTS] and `ptr`; its outputs are `gnt_idx` and `gnt_any`.
- The top level holds:
  - the FSM
  - `ptr`/`grant_idx` registers
  - the output register
  - the `in_ready` decode

## Test plan
- Single requester, 3-flit packet: `in_valid[2]=1` with flits 0xA,0xB,0xC (`last` on 0xC), `out_ready=1` → `grant_idx=2` at cycle 1; the output shows 0xA,0xB,0xC on cycles 2–4 with `out_last` on 0xC; `busy=0` at cycle 4.
- Round-robin fairness: all 5 requesters continuously send single-flit packets tagged with their index → output sequence 0,1,2,3,4,0, with one bubble between each.
- Packet lock: requester 1 sends a 4-flit packet with a 2-cycle `in_valid` gap mid-packet while requester 3 requests → no flit from 3 appears until after requester 1's `last`, then `grant_idx=3`.
- Backpressure: `out_ready=0` for 5 cycles mid-packet → `out_flit` is stable, `in_ready=0`, and no flit is lost or duplicated after release.
- Reset mid-packet: `rst=0` during flit 2 of 4 from requester 4 → `out_valid=0` and `busy=0` immediately; after release with requesters 0 and 4 both valid, requester 0 is granted first.
- Single-flit back-to-back: requester 0 alone sends 3 single-flit packets → 3 outputs over 6 cycles, `busy` toggling 1,0,1,0,1,0.
